afe_frame_sequencer: RTL
========================

Name: afe_frame_sequencer

Overview:
Parametrised successor to the pulse-ox AFE sample buffer.
- Walks the AFE result-register address space once per conversion-done pulse and collects NUM_CH channel words into one frame.
- Presents the frame downstream (FFT/time-domain buffers, Nios PIO bridge) through a valid/ready handshake with overrun detection.
- Also runs the one-shot diagnostic-register read that the FSM uses at bring-up.

Parameters:
NUM_CH, 6, channels per frame; channel k is read from address k (k = 0..NUM_CH-1)
DATA_W, 22, captured bits per channel, taken from in_strm_data[DATA_W-1:0]
ADDR_W, 3, width of out_addr; must satisfy 2**ADDR_W > max(NUM_CH-1, DIAG_ADDR)
RD_LAT, 1, settle cycles between address change and valid read data (range 0..7)
DIAG_ADDR, 6, address of the diagnostic register
DIAG_W, 14, diagnostic error bits, taken from in_strm_data[DIAG_W-1:0]

Ports:
clk  in  1  system clock
in_reset_n  in  1  asynchronous active-low reset
in_mode  in  2  00 idle, 01 diagnostic, 10 stream, 11 reserved (treated as 00)
in_strm_dn  in  1  conversion-done pulse from address-select logic
out_addr  out  ADDR_W  read-RAM address
in_strm_data  in  24  read-RAM data
out_frame  out  NUM_CH*DATA_W  channel k at bits [k*DATA_W +: DATA_W]
out_frame_valid  out  1  frame available
in_frame_ready  in  1  downstream accepts frame
out_overrun  out  1  sticky; a completed frame was dropped
out_busy  out  1  capture or diagnostic read in progress
out_diag_er  out  2  00 pending, 10 no error, 01 error
out_er_data  out  DIAG_W  latched diagnostic bits

Behaviour:
Reset:
- All outputs and internal state reset to 0; FSM in IDLE.

Mode 00/11:
- Every cycle, return to IDLE and clear all outputs, including out_overrun and any pending frame.
- A capture in progress is aborted.

Stream FSM: IDLE -> WAIT_DN -> CAP -> WAIT_DN.
- WAIT_DN: out_addr = 0. When in_strm_dn = 1, go to CAP with channel index ch = 0 and settle counter = RD_LAT.
- CAP:
  - Each channel occupies exactly RD_LAT+1 cycles: out_addr = ch for the whole slot.
  - On the slot's last edge, in_strm_data[DATA_W-1:0] is written into shadow slot ch.
  - After ch = NUM_CH-1, the shadow is committed and the FSM returns to WAIT_DN.
- in_strm_dn is ignored outside WAIT_DN; no queuing.
- out_busy = 1 in CAP.
- Latency: out_frame_valid rises NUM_CH*(RD_LAT+1)+1 edges after the edge that sampled in_strm_dn = 1. This is 13 edges at the defaults.

Output handshake:
- A transfer happens on any edge with valid & ready.
- out_frame changes only on commit.
- On commit:
  - if !valid, or ready on the same edge: load out_frame, valid = 1.
  - if valid & !ready: discard the new frame, keep the old one, set out_overrun = 1 (sticky until mode 00).
- Transfer without commit: valid = 0.
- Valid and frame contents are held stable while !ready.

Mode 01 (diagnostic):
- Drive out_addr = DIAG_ADDR for RD_LAT+1 cycles (out_busy = 1), then latch out_er_data = in_strm_data[DIAG_W-1:0].
- One edge later, set out_diag_er = 10 if the latched value is zero, else 01.
- The result is held while mode stays 01; the read is not repeated.

Mode change 10 <-> 01 mid-operation:
- Abort the current activity.
- Clear the shadow, pending frame and out_diag_er.
- Start the new mode from its first state on the next edge.

Width rules:
- Captured data is raw bits; no sign or offset conversion.
- in_strm_data bits above DATA_W are ignored.

Decomposition:
Package afe_seq_pkg:
- mode encodings (MODE_IDLE, MODE_DIAG, MODE_STRM)
- diag result codes (DIAG_PEND, DIAG_OK, DIAG_ERR)
- FSM state enum

Sub-module afe_frame_hold:
- output register with valid/ready and overrun flag
- parametrised on frame width

Test Plan:
1. Reset:
   - Stimulus: defaults, mode 10, channel k RAM word = 0x100000+k, pulse in_strm_dn.
   - Response: addr sequence 0,0,1,1,...,5,5; valid at edge 13; slot k = 0x100000+k; ready=1 clears valid next edge.
2. Back-pressure/overrun:
   - Stimulus: ready=0, two dn pulses.
   - Response: first frame held unchanged, second discarded, out_overrun=1; mode 00 clears overrun and valid.
3. Simultaneous commit and transfer:
   - Stimulus: ready=1 exactly on the second frame's commit edge.
   - Response: valid stays 1, out_frame equals the second frame, overrun=0.
4. Diagnostic:
   - Stimulus: DIAG_ADDR word = 0x000000.
   - Response: out_addr=6 for 2 cycles, out_diag_er=10.
   - Repeat with 0x000004: er_data=0x0004, out_diag_er=01.
5. Abort:
   - Stimulus: mode forced to 00 at channel 3 of a capture, then back to 10 with a new pulse.
   - Response: no valid from the aborted frame; the new frame is complete and correct.
6. Parameter sweep:
   - Stimulus: NUM_CH=4, DATA_W=24, RD_LAT=0, ADDR_W=3.
   - Response: frame valid 5 edges after in_strm_dn; full 24-bit words captured.

Source files
------------

// File: rtl/afe_seq_pkg.sv
// Shared encodings for the AFE frame sequencer.
// Mode codes, diagnostic result codes and controller state.
package afe_seq_pkg;

    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_DIAG = 2'b01;
    localparam logic [1:0] MODE_STRM = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    localparam logic [1:0] DIAG_PEND = 2'b00;
    localparam logic [1:0] DIAG_OK   = 2'b10;
    localparam logic [1:0] DIAG_ERR  = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_DN,
        ST_CAP,
        ST_DIAG_RD,
        ST_DIAG_CHK,
        ST_DIAG_DONE
    } state_t;

    function automatic logic [1:0] diag_code(input logic nonzero);
        return nonzero ? DIAG_ERR : DIAG_OK;
    endfunction

endpackage

// File: rtl/afe_frame_hold.sv
// Downstream frame register with valid/ready handshake.
// A commit while the previous frame is still pending drops the new frame.
module afe_frame_hold
    import afe_seq_pkg::*;
#(
    parameter int FRAME_W = 132
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               commit,
    input  logic [FRAME_W-1:0] frame_in,
    input  logic               ready,
    output logic [FRAME_W-1:0] frame,
    output logic               valid,
    output logic               overrun
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame   <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else if (clr) begin
            frame   <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else if (commit) begin
            if (!valid || ready) begin
                frame <= frame_in;
                valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/afe_frame_sequencer.sv
// Walks the AFE result registers into a frame per conversion-done pulse,
// and runs the one-shot diagnostic register read.
module afe_frame_sequencer
    import afe_seq_pkg::*;
#(
    parameter int NUM_CH    = 6,
    parameter int DATA_W    = 22,
    parameter int ADDR_W    = 3,
    parameter int RD_LAT    = 1,
    parameter int DIAG_ADDR = 6,
    parameter int DIAG_W    = 14
) (
    input  logic                     clk,
    input  logic                     in_reset_n,
    input  logic [1:0]               in_mode,
    input  logic                     in_strm_dn,
    output logic [ADDR_W-1:0]        out_addr,
    input  logic [23:0]              in_strm_data,
    output logic [NUM_CH*DATA_W-1:0] out_frame,
    output logic                     out_frame_valid,
    input  logic                     in_frame_ready,
    output logic                     out_overrun,
    output logic                     out_busy,
    output logic [1:0]               out_diag_er,
    output logic [DIAG_W-1:0]        out_er_data
);

    localparam int FRAME_W = NUM_CH * DATA_W;
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_t               state;
    logic [CH_W-1:0]      ch;
    logic [2:0]           cnt;
    logic [FRAME_W-1:0]   shadow;
    logic                 commit_q;
    logic                 mode_idle;
    logic                 strm_st;
    logic                 diag_st;
    logic                 to_diag;
    logic                 to_strm;
    logic                 clr;
    logic                 unused_bits;

    // Upper read-RAM bits are intentionally dropped.
    assign unused_bits = ^in_strm_data;

    always_comb begin
        mode_idle = (in_mode == MODE_IDLE) || (in_mode == MODE_RSVD);
        strm_st   = (state == ST_WAIT_DN) || (state == ST_CAP);
        diag_st   = (state == ST_DIAG_RD) || (state == ST_DIAG_CHK)
                 || (state == ST_DIAG_DONE);
        to_diag   = strm_st && (in_mode == MODE_DIAG);
        to_strm   = diag_st && (in_mode == MODE_STRM);
        clr       = mode_idle || to_diag || to_strm;
    end

    always_ff @(posedge clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state       <= ST_IDLE;
            ch          <= '0;
            cnt         <= '0;
            shadow      <= '0;
            commit_q    <= 1'b0;
            out_addr    <= '0;
            out_busy    <= 1'b0;
            out_diag_er <= DIAG_PEND;
            out_er_data <= '0;
        end else if (mode_idle) begin
            state       <= ST_IDLE;
            ch          <= '0;
            cnt         <= '0;
            shadow      <= '0;
            commit_q    <= 1'b0;
            out_addr    <= '0;
            out_busy    <= 1'b0;
            out_diag_er <= DIAG_PEND;
            out_er_data <= '0;
        end else if (to_diag) begin
            state       <= ST_DIAG_RD;
            ch          <= '0;
            cnt         <= 3'(RD_LAT);
            shadow      <= '0;
            commit_q    <= 1'b0;
            out_addr    <= ADDR_W'(DIAG_ADDR);
            out_busy    <= 1'b1;
            out_diag_er <= DIAG_PEND;
        end else if (to_strm) begin
            state       <= ST_WAIT_DN;
            ch          <= '0;
            cnt         <= '0;
            shadow      <= '0;
            commit_q    <= 1'b0;
            out_addr    <= '0;
            out_busy    <= 1'b0;
            out_diag_er <= DIAG_PEND;
        end else begin
            commit_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (in_mode == MODE_STRM) begin
                        state    <= ST_WAIT_DN;
                        out_addr <= '0;
                    end else begin
                        state    <= ST_DIAG_RD;
                        cnt      <= 3'(RD_LAT);
                        out_addr <= ADDR_W'(DIAG_ADDR);
                        out_busy <= 1'b1;
                    end
                end
                ST_WAIT_DN: begin
                    out_addr <= '0;
                    if (in_strm_dn) begin
                        state    <= ST_CAP;
                        ch       <= '0;
                        cnt      <= 3'(RD_LAT);
                        out_busy <= 1'b1;
                    end
                end
                ST_CAP: begin
                    if (cnt != 3'd0) begin
                        cnt <= cnt - 3'd1;
                    end else begin
                        shadow[int'(ch)*DATA_W +: DATA_W]
                            <= in_strm_data[DATA_W-1:0];
                        // Commit is registered so the hold stage
                        // sees the final slot already written.
                        if (int'(ch) == NUM_CH - 1) begin
                            state    <= ST_WAIT_DN;
                            ch       <= '0;
                            out_addr <= '0;
                            out_busy <= 1'b0;
                            commit_q <= 1'b1;
                        end else begin
                            ch       <= CH_W'(int'(ch) + 1);
                            out_addr <= ADDR_W'(int'(ch) + 1);
                            cnt      <= 3'(RD_LAT);
                        end
                    end
                end
                ST_DIAG_RD: begin
                    if (cnt != 3'd0) begin
                        cnt <= cnt - 3'd1;
                    end else begin
                        state       <= ST_DIAG_CHK;
                        out_er_data <= in_strm_data[DIAG_W-1:0];
                        out_addr    <= '0;
                        out_busy    <= 1'b0;
                    end
                end
                ST_DIAG_CHK: begin
                    state       <= ST_DIAG_DONE;
                    out_diag_er <= diag_code(out_er_data != '0);
                end
                ST_DIAG_DONE: begin
                    state <= ST_DIAG_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    afe_frame_hold #(
        .FRAME_W (FRAME_W)
    ) u_hold (
        .clk      (clk),
        .rst_n    (in_reset_n),
        .clr      (clr),
        .commit   (commit_q),
        .frame_in (shadow),
        .ready    (in_frame_ready),
        .frame    (out_frame),
        .valid    (out_frame_valid),
        .overrun  (out_overrun)
    );

endmodule
